// File: rtl/lfsr_gen.sv
// ============================================================================
// Module   : lfsr_gen
// Brief    : Parametrised Fibonacci LFSR with seed load, lock-up recovery
//            and hardware period measurement.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LFSR_EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] LFSR_STATE,
    output logic             LFSR_BIT,
    output logic             LFSR_PERIOD,
    output logic [WIDTH-1:0] PERIOD_LEN,
    output logic             PERIOD_VALID,
    output logic             LOCKUP
);

    localparam logic [WIDTH-1:0] C_CNT_MAX = '1;

    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be within 3..32");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_gen: SEED must be nonzero");
        end
    endgenerate

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q,   ref_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] len_q,   len_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;
    logic             lock_q,  lock_d;

    logic             fb_w;
    logic [WIDTH-1:0] step_w;

    assign fb_w   = ^(state_q & TAPS);
    assign step_w = {state_q[WIDTH-2:0], fb_w};

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        valid_d = valid_q;
        pulse_d = 1'b0;

        if (LOAD) begin
            state_d = LOAD_VAL;
            ref_d   = LOAD_VAL;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (LFSR_EN && lock_q) begin
            // Recovery from the all-zero trap is a restart, not a step.
            state_d = SEED;
            ref_d   = SEED;
            cnt_d   = '0;
        end else if (LFSR_EN) begin
            state_d = step_w;
            // A saturated counter means the reference is unreachable.
            if (step_w == ref_q && cnt_q != C_CNT_MAX) begin
                pulse_d = 1'b1;
                len_d   = cnt_q + 1'b1;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else if (cnt_q != C_CNT_MAX) begin
                cnt_d   = cnt_q + 1'b1;
            end
        end

        lock_d = (state_d == '0);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= SEED;
            ref_q   <= SEED;
            cnt_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            lock_q  <= lock_d;
        end
    end

    assign LFSR_STATE   = state_q;
    assign LFSR_BIT     = state_q[WIDTH-1];
    assign LFSR_PERIOD  = pulse_q;
    assign PERIOD_LEN   = len_q;
    assign PERIOD_VALID = valid_q;
    assign LOCKUP       = lock_q;

endmodule

`default_nettype wire
